// File: rtl/ysyx_23060208_ifu.sv
// rtl/ysyx_23060208_ifu.sv - single-outstanding instruction fetch unit with AXI read port
module ysyx_23060208_ifu #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h3000_0000
) (
    input  logic                      clock,
    input  logic                      reset,

    input  logic [DATA_WIDTH:0]       exu_to_ifu_bus,
    input  logic                      exu_to_ifu_valid,

    output logic [2*DATA_WIDTH-1:0]   ifu_to_idu_bus,
    output logic                      ifu_to_idu_valid,
    input  logic                      idu_allowin,

    output logic                      isram_arvalid,
    input  logic                      isram_arready,
    output logic [DATA_WIDTH-1:0]     isram_araddr,
    output logic [3:0]                isram_arid,
    output logic [7:0]                isram_arlen,
    output logic [2:0]                isram_arsize,
    output logic [1:0]                isram_arburst,

    input  logic                      isram_rvalid,
    output logic                      isram_rready,
    input  logic [2*DATA_WIDTH-1:0]   isram_rdata,
    input  logic [1:0]                isram_rresp,
    input  logic                      isram_rlast,
    input  logic [3:0]                isram_rid,

    output logic                      ifu_fault
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_AR,
        WAIT_R,
        VALID,
        WAIT_EXU
    } state_e;

    localparam logic [DATA_WIDTH-1:0] EBREAK = DATA_WIDTH'(32'h0010_0073);

    state_e                  state_q;
    logic [DATA_WIDTH-1:0]   pc_q;
    logic [DATA_WIDTH-1:0]   pc_d;
    logic [DATA_WIDTH-1:0]   inst_q;
    logic [DATA_WIDTH-1:0]   inst_d;
    logic [3:0]              arid_q;
    logic [3:0]              req_id;
    logic                    arvalid_q;
    logic                    rready_q;
    logic                    valid_q;
    logic                    fault_q;
    logic                    beat_ok;
    logic                    unused_inputs;

    // arid_q already advanced at the handshake, so the in-flight request id is one behind.
    assign req_id  = arid_q - 4'h1;
    assign beat_ok = isram_rvalid && (isram_rid == req_id);

    always_comb begin
        pc_d = exu_to_ifu_bus[DATA_WIDTH] ? exu_to_ifu_bus[DATA_WIDTH-1:0]
                                          : pc_q + DATA_WIDTH'(4);
        inst_d = pc_q[2] ? isram_rdata[2*DATA_WIDTH-1:DATA_WIDTH]
                         : isram_rdata[DATA_WIDTH-1:0];
        if (isram_rresp[1]) begin
            inst_d = EBREAK;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            inst_q    <= '0;
            arid_q    <= 4'h0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            valid_q   <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            fault_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    state_q   <= WAIT_AR;
                    arvalid_q <= 1'b1;
                end
                WAIT_AR: begin
                    if (isram_arready) begin
                        state_q   <= WAIT_R;
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        arid_q    <= arid_q + 4'h1;
                    end
                end
                WAIT_R: begin
                    // Beats with a foreign rid are taken (rready high) and dropped.
                    if (beat_ok) begin
                        state_q  <= VALID;
                        rready_q <= 1'b0;
                        valid_q  <= 1'b1;
                        inst_q   <= inst_d;
                        fault_q  <= isram_rresp[1];
                    end
                end
                VALID: begin
                    if (idu_allowin) begin
                        state_q <= WAIT_EXU;
                        valid_q <= 1'b0;
                    end
                end
                WAIT_EXU: begin
                    if (exu_to_ifu_valid) begin
                        state_q   <= WAIT_AR;
                        pc_q      <= pc_d;
                        arvalid_q <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    arvalid_q <= 1'b0;
                    rready_q  <= 1'b0;
                    valid_q   <= 1'b0;
                end
            endcase
        end
    end

    assign unused_inputs    = ^{isram_rlast, isram_rresp[0]};

    assign isram_arvalid    = arvalid_q;
    assign isram_araddr     = pc_q;
    assign isram_arid       = arid_q;
    assign isram_arlen      = 8'h00;
    assign isram_arsize     = 3'b010;
    assign isram_arburst    = 2'b01;
    assign isram_rready     = rready_q;
    assign ifu_to_idu_valid = valid_q;
    assign ifu_to_idu_bus   = {pc_q, inst_q};
    assign ifu_fault        = fault_q;

endmodule
